// File: rtl/booth_disp_pkg.sv
// Shared types and glyph helpers for the Booth product display stage.
package booth_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; anything that is not a decimal digit shows blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit unsigned to three BCD digits, one shift per cycle.
// FSM states:  IDLE | waiting for start
//              CONV | adjust nibbles >=5 by +3, then shift; eight passes
//              LOAD | result stable on bcd, done high for one cycle
module bin2bcd_seq
  import booth_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        done
);

  conv_state_e state_q, state_d;
  logic [11:0] bcd_q, bcd_d, bcd_adj;
  logic [7:0]  mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CONV;
      ST_CONV: if (cnt_q == 3'd7) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_d = bcd_q;
    mag_d = mag_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (start) begin
        bcd_d = '0;
        mag_d = bin;
        cnt_d = '0;
      end
      ST_CONV: begin
        bcd_d = {bcd_adj[10:0], mag_q[7]};
        mag_d = {mag_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_LOAD);
    bcd  = bcd_q;
  end

endmodule

// File: rtl/booth_display.sv
// Signed product to four-digit multiplexed seven-segment display (sign, hundreds, tens, units).
// Optional leading-zero blanking when BOOTH_DISP_LZB_EN is defined.
module booth_display
  import booth_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] producto,
  input  logic       valid,
  output logic       busy,
  output logic       ovr,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic        conv_busy, conv_done, start;
  logic [11:0] conv_bcd;
  logic [7:0]  mag;

  logic             sign_pend_q, sign_q, ovr_q;
  logic [11:0]      dig_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       sel_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             blank_h, blank_t;

  assign start = valid & ~conv_busy;
  // Two's-complement negate; -128 wraps to 8'h80, which reads correctly as unsigned 128.
  assign mag   = producto[7] ? (~producto + 8'd1) : producto;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (mag),
    .busy  (conv_busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
      dig_q       <= '0;
      ovr_q       <= 1'b0;
    end else begin
      if (start) sign_pend_q <= producto[7];
      if (valid && conv_busy) ovr_q <= 1'b1;
      if (conv_done) begin
        sign_q <= sign_pend_q;
        dig_q  <= conv_bcd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      sel_q <= 2'd0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        sel_q <= sel_q + 2'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

`ifdef BOOTH_DISP_LZB_EN
  assign blank_h = (dig_q[11:8] == 4'd0);
  assign blank_t = blank_h && (dig_q[7:4] == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    an_d  = ~(4'b0001 << sel_q);
    seg_d = SEG_BLANK;
    case (sel_q)
      2'd0: seg_d = bcd_to_seg(dig_q[3:0]);
      2'd1: seg_d = blank_t ? SEG_BLANK : bcd_to_seg(dig_q[7:4]);
      2'd2: seg_d = blank_h ? SEG_BLANK : bcd_to_seg(dig_q[11:8]);
      2'd3: seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
  end

  assign busy = conv_busy;
  assign ovr  = ovr_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_booth_display.sv
// Directed bench for booth_display with REFRESH_DIV=4; expectations are hand-derived glyphs.
module tb_booth_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] producto;
  logic       valid;
  logic       busy, ovr;
  logic [3:0] an;
  logic [6:0] seg;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000;
  localparam logic [6:0] BLK = 7'b1111111, MIN = 7'b0111111;
`ifdef BOOTH_DISP_LZB_EN
  localparam logic [6:0] H0 = BLK;
  localparam logic [6:0] T0 = BLK;
`else
  localparam logic [6:0] H0 = G0;
  localparam logic [6:0] T0 = G0;
`endif

  logic [6:0] cap_u, cap_t, cap_h, cap_s;

  booth_display #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .producto (producto),
    .valid    (valid),
    .busy     (busy),
    .ovr      (ovr),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] p);
    @(negedge clk);
    producto = p;
    valid    = 1'b1;
    @(negedge clk);
    valid    = 1'b0;
  endtask

  // One full scan is 16 cycles; record the glyph shown for each anode.
  task automatic capture();
    cap_u = 'x; cap_t = 'x; cap_h = 'x; cap_s = 'x;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: cap_u = seg;
        4'b1101: cap_t = seg;
        4'b1011: cap_h = seg;
        4'b0111: cap_s = seg;
        default: ;
      endcase
    end
  endtask

  task automatic check_disp(input string tag, input logic [6:0] s, input logic [6:0] h,
                            input logic [6:0] t, input logic [6:0] u);
    capture();
    check({tag, "_units"}, 16'(cap_u), 16'(u));
    check({tag, "_tens"},  16'(cap_t), 16'(t));
    check({tag, "_hund"},  16'(cap_h), 16'(h));
    check({tag, "_sign"},  16'(cap_s), 16'(s));
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; producto = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_an",   16'(an),   16'h000F);
    check("rst_seg",  16'(seg),  16'(BLK));
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_ovr",  16'(ovr),  16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check("first_an",  16'(an),  16'h000E);
    check("first_seg", 16'(seg), 16'(G0));

    send(8'd49);
    check("busy_E0", 16'(busy), 16'h0001);
    repeat (8) @(negedge clk);
    check("busy_E8", 16'(busy), 16'h0001);
    @(negedge clk);
    check("busy_E9", 16'(busy), 16'h0000);
    check_disp("p49", BLK, H0, G4, G9);

    send(8'hC8);
    repeat (12) @(negedge clk);
    check_disp("m56", MIN, H0, G5, G6);

    send(8'h80);
    repeat (12) @(negedge clk);
    check_disp("m128", MIN, G1, G2, G8);

    check("ovr_before", 16'(ovr), 16'h0000);
    send(8'd20);
    repeat (2) @(negedge clk);
    producto = 8'd1;
    valid    = 1'b1;
    @(negedge clk);
    valid    = 1'b0;
    check("ovr_set", 16'(ovr), 16'h0001);
    repeat (10) @(negedge clk);
    check_disp("p20", BLK, H0, G2, G0);
    check("ovr_sticky", 16'(ovr), 16'h0001);

    send(8'd64);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_an",   16'(an),   16'h000F);
    check("abort_seg",  16'(seg),  16'(BLK));
    check("abort_busy", 16'(busy), 16'h0000);
    check("abort_ovr",  16'(ovr),  16'h0000);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle", 16'(busy), 16'h0000);
    check_disp("abort", BLK, H0, T0, G0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
